// File: rtl/midi_msg_tx.sv
// midi_msg_tx: MIDI Note-On/Note-Off message transmitter.
// Commands are queued in a small FIFO, packed into 2- or 3-byte MIDI messages
// (with optional running status) and shifted out as 8N1 UART frames.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   msg_valid/ready   command handshake (transfer on valid & ready at clk edge)
//   msg_note_on       1 = Note-On (0x9n), 0 = Note-Off (0x8n)
//   msg_channel       MIDI channel n
//   msg_note          note number
//   msg_velocity      velocity
//   rs_clear          1-cycle pulse; forget the last status byte sent
//   tx                UART serial output, idle high (registered)
//   busy              FIFO non-empty, packer active, or frame shifting
//   fifo_count        entries currently queued
module midi_msg_tx #(
  parameter int CLK_HZ         = 100000000,
  parameter int BAUD           = 31250,
  parameter int FIFO_DEPTH     = 4,
  parameter int RUNNING_STATUS = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            msg_valid,
  output logic                            msg_ready,
  input  logic                            msg_note_on,
  input  logic [3:0]                      msg_channel,
  input  logic [6:0]                      msg_note,
  input  logic [6:0]                      msg_velocity,
  input  logic                            rs_clear,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int CNTW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STATUS = 3'd2;
  localparam logic [2:0] DATA1  = 3'd3;
  localparam logic [2:0] DATA2  = 3'd4;

  // FIFO
  logic [18:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty;

  // packer
  logic [2:0]  state, state_next;
  logic [18:0] cur;
  logic [7:0]  cur_status;
  logic [7:0]  last_status;
  logic        last_valid;
  logic        skip_status;

  // byte engine
  logic            shifting;
  logic [8:0]      shreg;
  logic [3:0]      bit_cnt;
  logic [CNTW-1:0] clk_cnt;
  logic            tx_q;
  logic            bit_end, frame_done, frame_near;
  logic            start;
  logic [7:0]      start_byte;

  assign fifo_empty = (count == '0);
  assign msg_ready  = (count != CW'(FIFO_DEPTH));
  assign push       = msg_valid && msg_ready;

  assign bit_end    = (clk_cnt == CNTW'(CPB - 1));
  assign frame_done = shifting && (bit_cnt == 4'd9) && bit_end;
  // One cycle before the last stop bit ends. DATA2 leaves here so that LOAD
  // coincides with the stop-bit end and the next message's start bit follows
  // without a gap.
  assign frame_near = shifting && (bit_cnt == 4'd9) && (clk_cnt == CNTW'(CPB - 2));

  assign pop = !fifo_empty && ((state == IDLE) || ((state == DATA2) && frame_near));

  assign cur_status  = {1'b1, 2'b00, cur[18], cur[17:14]};
  assign skip_status = (RUNNING_STATUS != 0) && last_valid && !rs_clear &&
                       (last_status == cur_status);

  // FIFO storage (no reset needed; emptiness is tracked by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {msg_note_on, msg_channel, msg_note, msg_velocity};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cur    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        cur    <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // packer next state and byte hand-off
  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_byte = '0;
    case (state)
      IDLE: if (!fifo_empty) state_next = LOAD;
      LOAD: begin
        start = 1'b1;
        if (skip_status) begin
          start_byte = {1'b0, cur[13:7]};
          state_next = DATA1;
        end else begin
          start_byte = cur_status;
          state_next = STATUS;
        end
      end
      STATUS: if (frame_done) begin
        start      = 1'b1;
        start_byte = {1'b0, cur[13:7]};
        state_next = DATA1;
      end
      DATA1: if (frame_done) begin
        start      = 1'b1;
        start_byte = {1'b0, cur[6:0]};
        state_next = DATA2;
      end
      DATA2: if (frame_near) state_next = fifo_empty ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // last-status tracking; a LOAD always records its own status, after rs_clear
  // has already forced the status byte out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_status <= '0;
      last_valid  <= 1'b0;
    end else if (state == LOAD) begin
      last_status <= cur_status;
      last_valid  <= 1'b1;
    end else if (rs_clear) begin
      last_valid  <= 1'b0;
    end
  end

  // byte engine: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifting <= 1'b0;
      shreg    <= '1;
      bit_cnt  <= '0;
      clk_cnt  <= '0;
      tx_q     <= 1'b1;
    end else if (start) begin
      shifting <= 1'b1;
      shreg    <= {1'b1, start_byte};
      bit_cnt  <= '0;
      clk_cnt  <= '0;
      tx_q     <= 1'b0;
    end else if (shifting) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          shifting <= 1'b0;
        end else begin
          tx_q    <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        clk_cnt <= clk_cnt + CNTW'(1);
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = !fifo_empty || (state != IDLE) || shifting;
  assign fifo_count = count;

endmodule

// File: doc/midi_msg_tx.md
Name: midi_msg_tx

Overview:
Parametrised MIDI message transmitter. Accepts Note-On and Note-Off commands on a valid/ready interface with a selectable MIDI channel and buffers them in a small FIFO. Each command is serialised as a 2- or 3-byte MIDI message on a UART line, with an optional running-status mode. It replaces the fixed single-byte, fixed-note sender and sits between control logic (buttons, sequencers) and the usb_tx / MIDI-out pin.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz.
BAUD, 31250, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 2).
FIFO_DEPTH, 4, number of message entries buffered. Power of two, >= 2.
RUNNING_STATUS, 1, 1 = omit repeated status bytes; 0 = always send the status byte.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
msg_valid  in  1  command present
msg_ready  out  1  FIFO can accept; a transfer occurs when msg_valid & msg_ready at a rising edge
msg_note_on  in  1  1 = Note-On (0x9n), 0 = Note-Off (0x8n)
msg_channel  in  4  MIDI channel n (0..15)
msg_note  in  7  note number
msg_velocity  in  7  velocity
rs_clear  in  1  1-cycle pulse; forgets the last status so the next message sends its status byte
tx  out  1  UART serial output, idle high
busy  out  1  high while the FIFO is non-empty, the packer is not IDLE, or a frame is shifting
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of entries currently queued

Behaviour:
- Reset values: tx=1, busy=0, msg_ready=1, fifo_count=0; FIFO emptied; packer in IDLE; last-status marked invalid. Reset takes effect immediately, including mid-frame: tx returns high asynchronously and the partial message is discarded.
- FIFO entry is 19 bits: {note_on, channel, note, velocity}. msg_ready = (fifo_count != FIFO_DEPTH).
  - A msg_valid while msg_ready=0 is ignored with no side effects.
  - Simultaneous push and pop on the same edge leaves fifo_count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Status byte = {1'b1, 2'b00, note_on, channel}. Data bytes = {1'b0, note} then {1'b0, velocity}. Velocity 0 on a Note-On is sent unchanged.
- Packer FSM states: IDLE, LOAD, STATUS, DATA1, DATA2.
  - IDLE -> LOAD when the FIFO is non-empty. The entry is popped on that edge.
  - LOAD makes the status decision. Skip the status byte only if RUNNING_STATUS=1, last-status is valid, and the status equals last-status; in that case go to DATA1, otherwise go to STATUS. last-status is updated to this status in LOAD.
  - STATUS -> DATA1 -> DATA2: each state hands its byte to the byte engine and advances when that frame's stop bit completes.
  - After DATA2 completes: go to LOAD if the FIFO is non-empty, else IDLE.
- rs_clear: invalidates last-status on the edge it is sampled. If rs_clear and a LOAD decision fall on the same cycle, the clear wins and the status byte is sent; last-status is then set to this message's status.
- Byte engine frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. A full frame is 10*CLKS_PER_BIT cycles.
  - The next start bit begins on the cycle immediately after the previous stop bit ends; there are no idle gaps within or between queued messages.
- Latency: a push at edge N into an empty, idle block pops at N+1 (LOAD). tx goes low, registered, from edge N+2.
- busy asserts from the edge after the first push and deasserts on the edge at which the last stop bit finishes with the FIFO empty.
- tx is a registered output with no combinational path from inputs.

Test Plan:
(Tests run with CLK_HZ=1000000, BAUD=100000, so CLKS_PER_BIT=10.)
1. After reset, push note_on=1, ch=0, note=0x3C, vel=0x64 -> tx low at push+2 edges; bytes decoded 0x90, 0x3C, 0x64 with 100 cycles per byte; busy falls after 300 cycles of frames.
2. With RUNNING_STATUS=1, push two Note-Ons on ch=2 back-to-back -> serial stream 0x92 3C 64 3E 64 (5 bytes, 500 cycles, no gaps). The same test with RUNNING_STATUS=0 -> 6 bytes.
3. Running-status break: push On ch=2, Off ch=2, On ch=3 -> 0x92 .. 0x82 .. 0x93 ..; pulse rs_clear between two identical messages -> status byte resent.
4. FIFO full: push 5 messages while transmitting (FIFO_DEPTH=4) -> msg_ready=0 at fifo_count=4, fifth held off and accepted once an entry pops; all five messages are emitted in order.
5. Simultaneous push and pop at count=1 -> fifo_count stays 1. A push attempted while full with msg_ready low -> dropped silently, count unchanged.
6. Assert reset mid-data-bit of byte 2 -> tx=1 immediately, busy=0, fifo_count=0. The next message after release sends its status byte (last-status invalid).
